// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : loader_pkg
// Brief  : Opcode enum, RV64 field constants and the instruction packer
//          shared by the program loader and its immediate checker.
// Rev    : 1.0  initial release
// ============================================================================
package loader_pkg;

    typedef enum logic [2:0] {
        LD   = 3'd0,
        SD   = 3'd1,
        ADDI = 3'd2,
        BEQ  = 3'd3,
        ADD  = 3'd4,
        SUB  = 3'd5
    } op_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_LD   = 3'b011;
    localparam logic [2:0] F3_SD   = 3'b011;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            LD, SD, ADDI, BEQ, ADD, SUB: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Immediates wider than the target format are truncated here.
    function automatic logic [31:0] encode_instr(
        input logic [2:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        logic [31:0] word;
        case (op)
            LD:   word = {imm[11:0], rs1, F3_LD, rd, OPC_LOAD};
            ADDI: word = {imm[11:0], rs1, F3_ADDI, rd, OPC_OPIMM};
            SD:   word = {imm[11:5], rs2, rs1, F3_SD, imm[4:0], OPC_STORE};
            BEQ:  word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                          imm[4:1], imm[11], OPC_BRANCH};
            ADD:  word = {F7_ADD, rs2, rs1, F3_ADD, rd, OPC_OP};
            SUB:  word = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_OP};
            default: word = NOP_WORD;
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_loader_imm_range_chk.sv
`default_nettype none
// ============================================================================
// Module : imm_range_chk
// Brief  : Flags immediates that the selected format cannot represent.
//          Present only when IMM_RANGE_CHECK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`ifdef IMM_RANGE_CHECK_EN
module imm_range_chk
    import loader_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [12:0] i_imm,
    output logic        o_imm_bad
);

    // A 13-bit value fits 12 signed bits exactly when its top two bits agree.
    always_comb begin
        o_imm_bad = 1'b0;
        case (i_op)
            LD, SD, ADDI: o_imm_bad = (i_imm[12] != i_imm[11]);
            BEQ:          o_imm_bad = i_imm[0];
            default:      o_imm_bad = 1'b0;
        endcase
    end

endmodule
`endif
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_loader
// Brief  : Packs decoded field bundles into RV64 words and streams them into
//          imem at one word per two cycles. Optional macro IMM_RANGE_CHECK_EN
//          rejects unrepresentable immediates instead of truncating them.
// Rev    : 1.0  initial release
// ============================================================================
module instr_encoder_loader
    import loader_pkg::*;
#(
    parameter int                 IMEM_AW   = 8,
    parameter logic [IMEM_AW-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [12:0]        in_imm,
    input  logic               in_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic [IMEM_AW:0]   count,
    output logic               done,
    output logic               full,
    output logic               err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_write = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [IMEM_AW-1:0] c_last_addr = {IMEM_AW{1'b1}};

    logic [1:0]         r_state;
    logic [IMEM_AW-1:0] r_ptr;
    logic               r_last;

    logic        w_accept;
    logic        w_op_legal;
    logic        w_imm_bad;
    logic [31:0] w_word;

    assign in_ready   = (r_state == c_st_idle) && !clr;
    assign w_accept   = in_valid && in_ready;
    assign w_op_legal = op_is_legal(in_op);
    assign w_word     = encode_instr(in_op, in_rd, in_rs1, in_rs2, in_imm);

`ifdef IMM_RANGE_CHECK_EN
    imm_range_chk u_imm_range_chk (
        .i_op      (in_op),
        .i_imm     (in_imm),
        .o_imm_bad (w_imm_bad)
    );
`else
    assign w_imm_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_ptr      <= BASE_ADDR;
            r_last     <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            done       <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else if (clr) begin
            r_state <= c_st_idle;
            r_ptr   <= BASE_ADDR;
            r_last  <= 1'b0;
            imem_we <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
            full    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (!w_op_legal || w_imm_bad) begin
                            err <= 1'b1;
                        end
                        if (w_imm_bad) begin
                            // Rejected bundle consumes no address.
                            if (in_last) begin
                                done    <= 1'b1;
                                r_state <= c_st_done;
                            end
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= r_ptr;
                            imem_wdata <= w_word;
                            r_last     <= in_last;
                            r_state    <= c_st_write;
                        end
                    end
                end
                c_st_write: begin
                    imem_we <= 1'b0;
                    count   <= count + 1'b1;
                    if (r_ptr == c_last_addr) begin
                        full    <= 1'b1;
                        done    <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                        if (r_last) begin
                            done    <= 1'b1;
                            r_state <= c_st_done;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                c_st_done: r_state <= c_st_done;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
